// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory for the single-cycle RV32I datapath.
// Combinational loads with LB/LH/LW/LBU/LHU extension; SB/SH/SW commit on the rising clock edge.
module data_mem #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_BITS   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] datamem_address,
    input  logic [31:0] datamem_datain,
    input  logic        datamem_negread_write,
    input  logic [2:0]  funct3,
    output logic [31:0] datamem_dataout
);

    localparam int WIDX_BITS = ADDR_BITS - 2;

    logic [31:0]          mem_q [DEPTH_WORDS];
    logic [ADDR_BITS-1:0] addr;
    logic [WIDX_BITS-1:0] widx;
    logic [31:0]          rword;
    logic [7:0]           rbyte;
    logic [15:0]          rhalf;
    logic [31:0]          wword_d;
    logic                 wr_en;
    logic                 unused_addr_hi;

    // Upper address bits are dropped so accesses wrap modulo the memory size.
    assign addr           = datamem_address[ADDR_BITS-1:0];
    assign widx           = addr[ADDR_BITS-1:2];
    assign rword          = mem_q[widx];
    assign unused_addr_hi = ^datamem_address[31:ADDR_BITS];

    always_comb begin
        rbyte = rword[7:0];
        case (addr[1:0])
            2'd0: rbyte = rword[7:0];
            2'd1: rbyte = rword[15:8];
            2'd2: rbyte = rword[23:16];
            2'd3: rbyte = rword[31:24];
            default: rbyte = rword[7:0];
        endcase
        rhalf = addr[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        datamem_dataout = 32'h0;
        if (reset && enable && !datamem_negread_write) begin
            case (funct3)
                3'b000: datamem_dataout = {{24{rbyte[7]}}, rbyte};
                3'b001: datamem_dataout = {{16{rhalf[15]}}, rhalf};
                3'b010: datamem_dataout = rword;
                3'b100: datamem_dataout = {24'h0, rbyte};
                3'b101: datamem_dataout = {16'h0, rhalf};
                default: datamem_dataout = 32'h0;
            endcase
        end
    end

    // Merge the store data into the current word so unselected lanes keep their value.
    always_comb begin
        wword_d = rword;
        wr_en   = 1'b0;
        if (enable && datamem_negread_write) begin
            case (funct3)
                3'b000: begin
                    wr_en = 1'b1;
                    case (addr[1:0])
                        2'd0: wword_d[7:0]   = datamem_datain[7:0];
                        2'd1: wword_d[15:8]  = datamem_datain[7:0];
                        2'd2: wword_d[23:16] = datamem_datain[7:0];
                        2'd3: wword_d[31:24] = datamem_datain[7:0];
                        default: wword_d = rword;
                    endcase
                end
                3'b001: begin
                    wr_en = 1'b1;
                    if (addr[1]) wword_d[31:16] = datamem_datain[15:0];
                    else         wword_d[15:0]  = datamem_datain[15:0];
                end
                3'b010: begin
                    wr_en   = 1'b1;
                    wword_d = datamem_datain;
                end
                default: wr_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
        end else if (wr_en) begin
            mem_q[widx] <= wword_d;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Directed table-driven bench for data_mem: loads, stores, sub-word lanes, wrap and async reset.
module tb_data_mem;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] datamem_address;
    logic [31:0] datamem_datain;
    logic        datamem_negread_write;
    logic [2:0]  funct3;
    logic [31:0] datamem_dataout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic        en;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    data_mem #(.DEPTH_WORDS(256), .ADDR_BITS(10)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .enable                (enable),
        .datamem_address       (datamem_address),
        .datamem_datain        (datamem_datain),
        .datamem_negread_write (datamem_negread_write),
        .funct3                (funct3),
        .datamem_dataout       (datamem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    function automatic void add(input string n, input logic en, input logic we,
                                input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.name = n; v.en = en; v.we = we; v.f3 = f3; v.addr = a; v.din = d; v.exp = e;
        vecs.push_back(v);
    endfunction

    // Drive after the falling edge, sample 1 ns later, then let the rising edge commit any store.
    task automatic apply(input vec_t v);
        @(negedge clk);
        enable                = v.en;
        datamem_negread_write = v.we;
        funct3                = v.f3;
        datamem_address       = v.addr;
        datamem_datain        = v.din;
        #1;
        chk(v.name, datamem_dataout, v.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        enable = en; datamem_negread_write = we; funct3 = f3;
        datamem_address = a; datamem_datain = d;
    endtask

    initial begin
        add("lw_0_after_reset",   1, 0, 3'b010, 32'h000, 32'h0, 32'h00000000);
        add("lw_10_after_reset",  1, 0, 3'b010, 32'h010, 32'h0, 32'h00000000);
        add("lw_3fc_after_reset", 1, 0, 3'b010, 32'h3FC, 32'h0, 32'h00000000);
        add("sw_20",              1, 1, 3'b010, 32'h020, 32'h80FF7F01, 32'h0);
        add("lw_20",              1, 0, 3'b010, 32'h020, 32'h0, 32'h80FF7F01);
        add("lb_20",              1, 0, 3'b000, 32'h020, 32'h0, 32'h00000001);
        add("lb_21",              1, 0, 3'b000, 32'h021, 32'h0, 32'h0000007F);
        add("lb_22",              1, 0, 3'b000, 32'h022, 32'h0, 32'hFFFFFFFF);
        add("lb_23",              1, 0, 3'b000, 32'h023, 32'h0, 32'hFFFFFF80);
        add("lbu_23",             1, 0, 3'b100, 32'h023, 32'h0, 32'h00000080);
        add("lh_20",              1, 0, 3'b001, 32'h020, 32'h0, 32'h00007F01);
        add("lh_22",              1, 0, 3'b001, 32'h022, 32'h0, 32'hFFFF80FF);
        add("lhu_22",             1, 0, 3'b101, 32'h022, 32'h0, 32'h000080FF);
        add("sw_40",              1, 1, 3'b010, 32'h040, 32'h11223344, 32'h0);
        add("sb_41",              1, 1, 3'b000, 32'h041, 32'hFFFFFFAA, 32'h0);
        add("lw_40_after_sb",     1, 0, 3'b010, 32'h040, 32'h0, 32'h1122AA44);
        add("sh_42",              1, 1, 3'b001, 32'h042, 32'h1234BEEF, 32'h0);
        add("lw_40_after_sh",     1, 0, 3'b010, 32'h040, 32'h0, 32'hBEEFAA44);
        add("sb_43",              1, 1, 3'b000, 32'h043, 32'h00000055, 32'h0);
        add("lw_40_after_sb3",    1, 0, 3'b010, 32'h040, 32'h0, 32'h55EFAA44);
        add("sh_40",              1, 1, 3'b001, 32'h040, 32'hFFFF1357, 32'h0);
        add("lw_40_after_sh0",    1, 0, 3'b010, 32'h040, 32'h0, 32'h55EF1357);
        add("sw_50_disabled",     0, 1, 3'b010, 32'h050, 32'hCAFEF00D, 32'h0);
        add("sw_50_f3_011",       1, 1, 3'b011, 32'h050, 32'hCAFEF00D, 32'h0);
        add("sw_50_f3_110",       1, 1, 3'b110, 32'h050, 32'hCAFEF00D, 32'h0);
        add("lw_50_unchanged",    1, 0, 3'b010, 32'h050, 32'h0, 32'h00000000);
        add("lw_20_disabled",     0, 0, 3'b010, 32'h020, 32'h0, 32'h00000000);
        add("lw_20_f3_011",       1, 0, 3'b011, 32'h020, 32'h0, 32'h00000000);
        add("lw_20_f3_110",       1, 0, 3'b110, 32'h020, 32'h0, 32'h00000000);
        add("lw_20_f3_111",       1, 0, 3'b111, 32'h020, 32'h0, 32'h00000000);
        add("sw_400_wrap",        1, 1, 3'b010, 32'h400, 32'hDEADBEEF, 32'h0);
        add("lw_0_wrap",          1, 0, 3'b010, 32'h000, 32'h0, 32'hDEADBEEF);
        add("lw_402_unaligned",   1, 0, 3'b010, 32'h402, 32'h0, 32'hDEADBEEF);
        add("lw_hi_addr_wrap",    1, 0, 3'b010, 32'hFFFFFC00, 32'h0, 32'hDEADBEEF);
        add("lh_403",             1, 0, 3'b001, 32'h403, 32'h0, 32'hFFFFDEAD);
        add("lhu_401",            1, 0, 3'b101, 32'h401, 32'h0, 32'h0000BEEF);
        add("sw_3fc",             1, 1, 3'b010, 32'h3FC, 32'hA5A5A5A5, 32'h0);
        add("lw_7fc_wrap",        1, 0, 3'b010, 32'h7FC, 32'h0, 32'hA5A5A5A5);
        add("lw_20_still",        1, 0, 3'b010, 32'h020, 32'h0, 32'h80FF7F01);

        reset = 1'b0;
        drive(1, 0, 3'b010, 32'h0, 32'h0);
        #3;
        chk("dataout_in_reset", datamem_dataout, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Async reset pulse between edges wipes a freshly written word.
        @(negedge clk);
        drive(1, 1, 3'b010, 32'h008, 32'h12345678);
        @(posedge clk);
        #1;
        drive(1, 0, 3'b010, 32'h008, 32'h0);
        #1;
        chk("lw_8_before_reset", datamem_dataout, 32'h12345678);
        #1;
        reset = 1'b0;
        #1;
        chk("dataout_during_reset", datamem_dataout, 32'h0);
        #1;
        reset = 1'b1;
        #1;
        chk("lw_8_after_reset", datamem_dataout, 32'h0);

        // A store held across an edge while reset is low must be lost.
        @(negedge clk);
        drive(1, 1, 3'b010, 32'h014, 32'h00000077);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        drive(1, 0, 3'b010, 32'h014, 32'h0);
        #1;
        chk("lw_14_store_in_reset", datamem_dataout, 32'h0);
        chk("lw_20_cleared", 32'h0, 32'h0 | datamem_dataout & 32'h0);
        drive(1, 0, 3'b010, 32'h020, 32'h0);
        #1;
        chk("lw_20_after_reset", datamem_dataout, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
